bp_dma_link_packet_buffer: RTL
==============================

// Module: bp_dma_link_packet_buffer
// PURPOSE
//  Wormhole-aware elastic buffer on the tile-side DMA link, between the L2 tile's DMA port and the DMA-NoC socket.
//  Holds up to els_p flits and tracks packet boundaries from the header length field on both sides.
//  Lets the tile quiesce its memory traffic cleanly at a packet boundary (for clock/power gating and reconfiguration).
//  Counts accepted packets.
// PARAMETERS
//  flit_width_p    64  wormhole flit width (dma_noc_flit_width_p at instantiation)
//  cord_width_p     8  header cord field width; field is at flit[cord_width_p-1:0]
//  len_width_p      4  header length field at flit[cord_width_p+:len_width_p] = number of body flits after header
//  els_p            4  buffer depth in flits (power of 2, >=2)
//  count_width_p   16  packet counter width
// PORTS
//  clk_i           in   1              tile clock
//  reset_n_i       in   1              asynchronous active-low reset
//  in_data_i       in   flit_width_p   upstream flit
//  in_v_i          in   1              upstream valid
//  in_ready_and_o  out  1              ready (ready-and: transfer when v & ready)
//  out_data_o      out  flit_width_p   downstream flit (to DMA socket tile_link_i)
//  out_v_o         out  1              downstream valid
//  out_ready_and_i in   1              downstream ready
//  quiesce_i       in   1              request: stop accepting new packets
//  quiesced_o      out  1              buffer empty and both sides at packet boundary while quiesce_i
//  pkt_count_o     out  count_width_p  headers accepted on input since reset, wraps
//  in_sop_o        out  1              input side expects a header (packet boundary)
// BEHAVIOUR
//  Reset (reset_n_i low, async): storage pointers=0, occupancy=0, both trackers in HDR, pkt_count_o=0.
//   Outputs during reset: out_v_o=0, in_ready_and_o=0, quiesced_o=0, in_sop_o=1.
//   Any in-flight packet is discarded; no partial flits emerge after reset release.
//  Storage: circular FIFO, registered. A flit accepted in cycle N is visible on out_data_o/out_v_o in cycle N+1 at the earliest. No combinational in->out path.
//  Full: in_ready_and_o=0 when occupancy==els_p. It depends only on registered state plus quiesce gating.
//   Simultaneous enq+deq when full is not allowed: ready is already low.
//   Simultaneous enq+deq at any other occupancy leaves occupancy unchanged.
//  Empty: out_v_o=0. out_data_o holds the last value, which is don't-care.
//  Pointers wrap modulo els_p. Occupancy is a ($clog2(els_p)+1)-bit counter.
//  Length tracker (instantiated once on the input side, once on the output side), per transfer:
//   HDR  : on a header flit with len=L: L==0 -> stay HDR; else load rem=L -> BODY.
//   BODY : each flit decrements rem; when rem==1 and a flit transfers -> HDR.
//   sop = (state==HDR).
//  pkt_count_o increments by 1 on each input-side header transfer; wraps at 2^count_width_p.
//  Quiesce:
//   The gate is quiesce_i AND the input tracker in HDR.
//   The gate forces in_ready_and_o=0, so a packet already started always completes, even if quiesce_i rises mid-packet.
//   Deasserting quiesce_i re-opens the input in the next cycle; there is no other state.
//  quiesced_o = quiesce_i & occupancy==0 & in tracker HDR & out tracker HDR. It is combinational from registered state and quiesce_i.
//  Output side is never gated by quiesce: the buffer drains fully.
// STRUCTURE
//  Shared package (bp_me_pkg): wormhole header field offset/width helpers for DMA flits, and the tracker state enum {e_hdr, e_body}.
//  Sub-module: bp_wormhole_len_tracker (clk_i, reset_n_i, v_i=transfer, data_i, sop_o), instantiated twice.
//  Top level holds the FIFO, occupancy counter, quiesce gating and packet counter.
// TESTING
//  1 Reset, then one len=2 packet (hdr, b0, b1) with out ready: 3 flits out in order, first flit 1 cycle after accept; pkt_count_o=1.
//  2 out_ready_and_i=0, push 5 flits, els_p=4: in_ready_and_o drops after 4th; release ready -> all 5 out in order; no loss or duplication.
//  3 Back-to-back len=0 headers at full rate with out ready: one per cycle, occupancy stays <=1, pkt_count_o increments each cycle.
//  4 Assert quiesce_i after header of len=3 packet: remaining 3 body flits accepted, next header refused. quiesced_o=1 once the last flit leaves; deassert -> header accepted next cycle.
//  5 Drop reset_n_i mid-packet (2 of 4 flits in): out_v_o=0 immediately, pkt_count_o=0. After release, a fresh header is treated as a header (in_sop_o=1).
//  6 Counter wrap: preload count_width_p=4 build, send 17 headers -> pkt_count_o=1.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared definitions for the tile-side DMA wormhole link.
//  - wh_len_state_e : state of a wormhole length tracker (header expected / inside body)
//  - wh_len_lsb()   : bit offset of the header length field inside a DMA flit;
//                     the cord field occupies the low bits, the length follows it.
// No ports (package).
package bp_me_pkg;

    typedef enum logic {
        e_hdr  = 1'b0,
        e_body = 1'b1
    } wh_len_state_e;

    // Default DMA NoC flit geometry.
    localparam int dma_noc_flit_width_p = 64;
    localparam int dma_noc_cord_width_p = 8;
    localparam int dma_noc_len_width_p  = 4;

    // Cord sits at flit[cord_width-1:0], so the length field starts right above it.
    function automatic int wh_len_lsb(input int cord_width);
        return cord_width;
    endfunction

endpackage

// File: rtl/bp_wormhole_len_tracker.sv
// Wormhole packet-boundary tracker for one side of a link.
// Follows the header length field across transfers so that sop_o is high
// exactly when the next transferred flit will be a header.
// Ports:
//  clk_i      in   clock
//  reset_n_i  in   asynchronous active-low reset (returns to e_hdr)
//  v_i        in   a flit transfers on this side this cycle
//  data_i     in   header length field of the transferring flit (number of body flits)
//  sop_o      out  tracker is at a packet boundary (next flit is a header)
module bp_wormhole_len_tracker
    import bp_me_pkg::*;
#(
    parameter int len_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [len_width_p-1:0] data_i,
    output logic                   sop_o
);

    wh_len_state_e          state_reg, state_next;
    logic [len_width_p-1:0] rem_reg, rem_next;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= e_hdr;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        case (state_reg)
            e_hdr: begin
                // A zero-length packet is a lone header: stay at the boundary.
                if (v_i && (data_i != '0)) begin
                    rem_next   = data_i;
                    state_next = e_body;
                end
            end
            e_body: begin
                if (v_i) begin
                    rem_next = rem_reg - 1'b1;
                    if (rem_reg == len_width_p'(1)) begin
                        state_next = e_hdr;
                    end
                end
            end
            default: state_next = e_hdr;
        endcase
    end

    always_comb begin
        sop_o = (state_reg == e_hdr);
    end

endmodule

// File: rtl/bp_dma_link_packet_buffer.sv
// Wormhole-aware elastic buffer between the L2 tile DMA port and the DMA-NoC socket.
// Holds up to els_p flits, tracks packet boundaries on both sides, can be told to
// stop taking new packets (quiesce) so the tile can be gated at a clean boundary,
// and counts accepted packet headers.
// Ports:
//  clk_i            in   tile clock
//  reset_n_i        in   asynchronous active-low reset
//  in_data_i        in   upstream flit
//  in_v_i           in   upstream valid
//  in_ready_and_o   out  upstream ready (transfer when valid & ready)
//  out_data_o       out  downstream flit
//  out_v_o          out  downstream valid
//  out_ready_and_i  in   downstream ready
//  quiesce_i        in   stop accepting new packets
//  quiesced_o       out  empty and both sides at a boundary while quiesce_i is high
//  pkt_count_o      out  headers accepted since reset (wraps)
//  in_sop_o         out  input side expects a header
module bp_dma_link_packet_buffer
    import bp_me_pkg::*;
#(
    parameter int flit_width_p  = dma_noc_flit_width_p,
    parameter int cord_width_p  = dma_noc_cord_width_p,
    parameter int len_width_p   = dma_noc_len_width_p,
    parameter int els_p         = 4,
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [flit_width_p-1:0]  in_data_i,
    input  logic                     in_v_i,
    output logic                     in_ready_and_o,
    output logic [flit_width_p-1:0]  out_data_o,
    output logic                     out_v_o,
    input  logic                     out_ready_and_i,
    input  logic                     quiesce_i,
    output logic                     quiesced_o,
    output logic [count_width_p-1:0] pkt_count_o,
    output logic                     in_sop_o
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int occ_width_lp = ptr_width_lp + 1;
    localparam int len_lsb_lp   = wh_len_lsb(cord_width_p);
    localparam logic [occ_width_lp-1:0] els_lp = occ_width_lp'(els_p);

    logic [flit_width_p-1:0]  mem [els_p];
    logic [ptr_width_lp-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [occ_width_lp-1:0]  occ_reg, occ_next;
    logic [count_width_p-1:0] pkt_count_reg;

    logic enq, deq;
    logic in_sop, out_sop;
    logic quiesce_gate;

    // Gate only at a boundary so a started packet always completes.
    assign quiesce_gate   = quiesce_i & in_sop;
    // reset_n_i term keeps ready low while reset is held, not just after it.
    assign in_ready_and_o = reset_n_i & (occ_reg != els_lp) & ~quiesce_gate;
    assign out_v_o        = (occ_reg != '0);
    assign out_data_o     = mem[rd_ptr_reg];

    assign enq = in_v_i & in_ready_and_o;
    assign deq = out_v_o & out_ready_and_i;

    assign quiesced_o  = reset_n_i & quiesce_i & (occ_reg == '0) & in_sop & out_sop;
    assign in_sop_o    = in_sop;
    assign pkt_count_o = pkt_count_reg;

    // Storage array has no reset; its content is only observed while occupied.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr_reg] <= in_data_i;
        end
    end

    always_comb begin
        occ_next = occ_reg;
        case ({enq, deq})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            pkt_count_reg <= '0;
        end else begin
            occ_reg <= occ_next;
            // els_p is a power of two, so natural pointer overflow is the wrap.
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (enq && in_sop) begin
                pkt_count_reg <= pkt_count_reg + 1'b1;
            end
        end
    end

    bp_wormhole_len_tracker #(
        .len_width_p (len_width_p)
    ) in_tracker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq),
        .data_i    (in_data_i[len_lsb_lp +: len_width_p]),
        .sop_o     (in_sop)
    );

    bp_wormhole_len_tracker #(
        .len_width_p (len_width_p)
    ) out_tracker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (deq),
        .data_i    (out_data_o[len_lsb_lp +: len_width_p]),
        .sop_o     (out_sop)
    );

endmodule
